// File: rtl/lc3_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// lc3_mem_arb_pkg
// Shared types and default widths for the LC3 unified-memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE -> ISSUE -> WAIT -> RESP -> IDLE)
//   arb_owner_e : which requester owns the transaction in flight
//   starve_inc  : saturating increment for the fetch starvation counter
// -----------------------------------------------------------------------------
package lc3_mem_arb_pkg;

    localparam int ARB_ADDR_W     = 16;
    localparam int ARB_DATA_W     = 16;
    localparam int ARB_MEM_LAT    = 2;
    localparam int ARB_STARVE_MAX = 4;

    // Wide enough for STARVE_MAX up to 15 and MEM_LAT up to 4.
    localparam int ARB_STARVE_W   = 4;
    localparam int ARB_LAT_W      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_e;

    function automatic logic [ARB_STARVE_W-1:0] starve_inc(
        input logic [ARB_STARVE_W-1:0] cnt,
        input logic [ARB_STARVE_W-1:0] max_cnt
    );
        return (cnt >= max_cnt) ? cnt : cnt + ARB_STARVE_W'(1);
    endfunction

endpackage

// File: rtl/lc3_arb_prio.sv
// -----------------------------------------------------------------------------
// lc3_arb_prio
// Winner selection between fetch and data requests plus the fetch starvation
// counter. Data normally wins; once data has been granted STARVE_MAX times in
// a row while fetch was waiting, fetch wins the next arbitration.
// Ports:
//   clock, reset_n     : clock, async active-low reset
//   i_idle             : arbiter may grant this cycle
//   i_if_req, i_da_req : fetch / data requests
//   o_if_gnt, o_da_gnt : combinational, mutually exclusive grants
// -----------------------------------------------------------------------------
module lc3_arb_prio
    import lc3_mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_idle,
    input  logic i_if_req,
    input  logic i_da_req,
    output logic o_if_gnt,
    output logic o_da_gnt
);

    logic [ARB_STARVE_W-1:0] r_starve_cnt;
    logic                    w_starved;
    logic                    w_fetch_wins;

    assign w_starved    = (r_starve_cnt == ARB_STARVE_W'(STARVE_MAX));
    assign w_fetch_wins = i_if_req && (!i_da_req || w_starved);

    // Both grants derive from one select term, so they can never overlap.
    assign o_if_gnt = i_idle && w_fetch_wins;
    assign o_da_gnt = i_idle && i_da_req && !w_fetch_wins;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
        end else if (o_if_gnt) begin
            r_starve_cnt <= '0;
        end else if (o_da_gnt && i_if_req) begin
            r_starve_cnt <= starve_inc(r_starve_cnt, ARB_STARVE_W'(STARVE_MAX));
        end
    end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// -----------------------------------------------------------------------------
// lc3_mem_arbiter
// Single-port arbiter sharing one unified instruction/data memory between the
// LC3 fetch stage and the memaccess stage. One transaction in flight at a time:
// grant in IDLE, one ISSUE cycle driving the memory strobe, MEM_LAT WAIT
// cycles, then one RESP cycle pulsing the owner's rvalid.
// Ports:
//   clock, reset_n                  : clock, async active-low reset
//   if_req/if_addr                  : fetch read request
//   if_gnt/if_rvalid/if_rdata       : fetch grant, read-data pulse and data
//   da_req/da_we/da_addr/da_wdata   : data read/write request
//   da_gnt/da_rvalid/da_rdata       : data grant, completion pulse, read data
//   mem_en/mem_we/mem_addr/mem_wdata: memory strobe, valid only in ISSUE
//   mem_rdata                       : memory read data, valid MEM_LAT later
//   busy                            : a transaction is in progress
// -----------------------------------------------------------------------------
module lc3_mem_arbiter
    import lc3_mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int MEM_LAT    = ARB_MEM_LAT,
    parameter int STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              da_req,
    input  logic              da_we,
    input  logic [ADDR_W-1:0] da_addr,
    input  logic [DATA_W-1:0] da_wdata,
    output logic              da_gnt,
    output logic              da_rvalid,
    output logic [DATA_W-1:0] da_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_e           r_state;
    arb_owner_e           r_owner;
    logic                 r_we;
    logic [ARB_LAT_W-1:0] r_lat_cnt;
    logic                 r_mem_en;
    logic                 r_mem_we;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [DATA_W-1:0]    r_mem_wdata;
    logic                 r_if_rvalid;
    logic                 r_da_rvalid;
    logic [DATA_W-1:0]    r_if_rdata;
    logic [DATA_W-1:0]    r_da_rdata;
    logic                 r_busy;

    logic                 w_idle;
    logic                 w_if_gnt;
    logic                 w_da_gnt;

    // Grants are combinational; holding them off while reset is asserted keeps
    // every output at 0 during reset even if a requester is already active.
    assign w_idle = (r_state == IDLE) && reset_n;

    lc3_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_idle   (w_idle),
        .i_if_req (if_req),
        .i_da_req (da_req),
        .o_if_gnt (w_if_gnt),
        .o_da_gnt (w_da_gnt)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_owner     <= OWN_FETCH;
            r_we        <= 1'b0;
            r_lat_cnt   <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rvalid <= 1'b0;
            r_da_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_da_rdata  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_da_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // The mem_* registers double as the latch for the granted
                    // request; owner and we are kept separately for capture.
                    if (w_da_gnt) begin
                        r_state     <= ISSUE;
                        r_busy      <= 1'b1;
                        r_owner     <= OWN_DATA;
                        r_we        <= da_we;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= da_we;
                        r_mem_addr  <= da_addr;
                        r_mem_wdata <= da_we ? da_wdata : '0;
                    end else if (w_if_gnt) begin
                        r_state     <= ISSUE;
                        r_busy      <= 1'b1;
                        r_owner     <= OWN_FETCH;
                        r_we        <= 1'b0;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr;
                        r_mem_wdata <= '0;
                    end
                end
                ISSUE: begin
                    r_state     <= WAIT;
                    r_lat_cnt   <= ARB_LAT_W'(MEM_LAT - 1);
                    r_mem_en    <= 1'b0;
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                end
                WAIT: begin
                    // Last WAIT cycle: memory data is valid now, capture it and
                    // raise the owner's rvalid for the RESP cycle.
                    if (r_lat_cnt == '0) begin
                        r_state <= RESP;
                        if (r_owner == OWN_FETCH) begin
                            r_if_rdata  <= mem_rdata;
                            r_if_rvalid <= 1'b1;
                        end else begin
                            r_da_rdata  <= r_we ? '0 : mem_rdata;
                            r_da_rvalid <= 1'b1;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt - ARB_LAT_W'(1);
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign if_gnt    = w_if_gnt;
    assign da_gnt    = w_da_gnt;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign da_rvalid = r_da_rvalid;
    assign da_rdata  = r_da_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;

endmodule

// File: doc/lc3_mem_arbiter.md
# lc3_mem_arbiter

Single-port memory arbiter for the LC3 pipeline. It shares one unified instruction/data memory between the fetch stage (instruction reads) and the memaccess stage (data reads/writes, including both accesses of LDI/STI). It sits between those two stages and the memory model, which is driven by the imem/dmem agents. Only one transaction is in flight at a time. Data accesses have priority, and a starvation counter guarantees fetch progress.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `MEM_LAT`, 2, cycles from the `mem_en` cycle to valid `mem_rdata`; legal range 1..4
- `STARVE_MAX`, 4, maximum consecutive data grants while fetch is waiting; legal range 1..15

Clock and reset (already decided): one clock, `clock`; reset `reset_n` is asynchronous and active-low.

- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  async active-low reset
- `if_req`  in  1  fetch read request
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch request accepted
- `if_rvalid`  out  1  fetch read data valid, 1-cycle pulse
- `if_rdata`  out  DATA_W  fetch read data
- `da_req`  in  1  data request
- `da_we`  in  1  1 = write, 0 = read
- `da_addr`  in  ADDR_W  data address
- `da_wdata`  in  DATA_W  write data
- `da_gnt`  out  1  data request accepted
- `da_rvalid`  out  1  data read data valid, or write completion; 1-cycle pulse
- `da_rdata`  out  DATA_W  data read data; 0 for writes
- `mem_en`, `mem_we`  out  1  memory strobe and write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data
- `busy`  out  1  state is not IDLE

## Operation
- FSM states:
  - IDLE: grants a request; next state is ISSUE.
  - ISSUE: one cycle; next state is WAIT.
  - WAIT: MEM_LAT cycles, counted down; next state is RESP.
  - RESP: one cycle; next state is IDLE.
- Grant is combinational and given only in IDLE.
  - Winner selection: `da_req` wins, except when `if_req` is high and `starve_cnt == STARVE_MAX`; then fetch wins.
  - `if_gnt` and `da_gnt` are never high together.
- On grant, the arbiter latches address, we, wdata and the owner (FETCH or DATA).
- `starve_cnt` rules:
  - Increments (saturating) when data is granted while `if_req` is high.
  - Clears when fetch is granted.
  - Is unchanged otherwise.
- Requester rules:
  - Hold req, addr, we and wdata stable until gnt.
  - Req may drop after gnt.
  - Dropping req before gnt is legal; nothing is issued.
- ISSUE drives `mem_en=1`, `mem_we` (data writes only) and the latched addr/wdata. All `mem_*` outputs are 0 in every other state.
- Read capture: on the last WAIT cycle, `mem_rdata` is registered into the owner's rdata register. Writes clear `da_rdata` to 0.
- RESP pulses the owner's rvalid only. The rdata outputs hold their value until the next capture.
- Reset (any time, including mid-transaction):
  - FSM goes to IDLE; `starve_cnt`, both rdata outputs and all outputs go to 0.
  - The in-flight transaction is dropped with no rvalid; the requester must reissue.

## Timing
- Grant at cycle T.
  - T+1: `mem_en` high.
  - T+1+MEM_LAT: `mem_rdata` sampled.
  - T+2+MEM_LAT: rvalid pulse.
  - T+3+MEM_LAT: back in IDLE; earliest next grant.
- Grant-to-rvalid latency is MEM_LAT+2. Back-to-back throughput is one access per MEM_LAT+3 cycles.
- A grant at T with `da_req`/`if_req` asserted combinationally in that cycle is legal; there is no request-registration delay.
- Under continuous dual requests, the grant sequence repeats with period STARVE_MAX+1: STARVE_MAX data grants, then 1 fetch grant.
- `busy` is high from T+1 through T+2+MEM_LAT.

## Structure
- Shared package `lc3_mem_arb_pkg` contains:
  - `arb_state_e` {IDLE, ISSUE, WAIT, RESP}
  - `arb_owner_e` {OWN_FETCH, OWN_DATA}
  - default width constants
- One sub-module, `lc3_arb_prio`, holds the winner-select logic and the `starve_cnt` register. The top level holds the FSM, latency counter and datapath latches.

## Test plan
All scenarios use MEM_LAT=2, STARVE_MAX=4 and a model memory with 2-cycle read latency.
1. Fetch read of 0x3000 at cycle 0, memory word 0x1234 -> `if_gnt` at c0; `mem_en=1` with `mem_addr=0x3000` at c1; `if_rvalid=1` with `if_rdata=0x1234` at c4; `da_rvalid` stays 0; next grant possible at c5.
2. `if_req` and `da_req` (read, 0x4000) raised together at c0 -> `da_gnt` at c0, `if_gnt` at c5; `da_rvalid` at c4, `if_rvalid` at c9.
3. `if_req` and `da_req` held high for 12 grants -> grant order D,D,D,D,F,D,D,D,D,F,D,D; `starve_cnt` is 0 after each F.
4. Data write: `da_we=1`, addr 0x4000, wdata 0xBEEF at c0 -> at c1 `mem_en=1`, `mem_we=1`, addr 0x4000, wdata 0xBEEF; at c4 `da_rvalid=1` with `da_rdata=0`; a subsequent read of 0x4000 returns 0xBEEF.
5. Fetch granted at c0, `reset_n` low at c2 for 2 cycles -> every output is 0 from c2 onward with no rvalid; `busy` is 0. Fetch reissued one cycle after release is granted immediately and completes with latency 4.
6. `da_req` pulsed for one cycle while `busy`, dropped before IDLE -> no `da_gnt`, no memory access; only the original transaction completes.
